// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encoding and default parameter values.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_FLUSH    = 3'd1,
        ST_WAIT_MEM = 3'd2,
        ST_HALT     = 3'd3
    } pipe_state_e;

    localparam int unsigned DEF_FLUSH_BUBBLES = 1;
    localparam int unsigned DEF_MEM_TIMEOUT   = 15;
    localparam int unsigned DEF_CNT_W         = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: clear wins, otherwise step unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign count = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes and redirects the front end
// on mispredicts, load-use hazards, slow instruction fetch and halt.
// Performance counters are built only when PIPE_PERF_CNT_EN is defined;
// otherwise mispredict_cnt and stall_cnt read zero.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_BUBBLES = DEF_FLUSH_BUBBLES,
    parameter int unsigned MEM_TIMEOUT   = DEF_MEM_TIMEOUT,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mispredict_e,
    input  logic             load_use_d,
    input  logic             imem_ready,
    input  logic             halt_req,
    output logic             pc_enable,
    output logic             if_id_enable,
    output logic             if_id_clr,
    output logic             id_ex_clr,
    output logic             redirect,
    output logic             mem_err,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] mispredict_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_BUBBLES);
    localparam logic [7:0] TMO_LIMIT  = 8'(MEM_TIMEOUT);

    pipe_state_e state_d, state_q;
    logic [2:0]  flush_d, flush_q;
    logic [7:0]  tmo_d, tmo_q;
    logic [7:0]  tmo_base;
    logic        mem_err_d, mem_err_q;

    // Output decode and next-state logic; inputs ranked mispredict > halt > load-use > fetch wait.
    always_comb begin
        state_d      = state_q;
        flush_d      = flush_q;
        tmo_d        = tmo_q;
        tmo_base     = 8'd0;
        mem_err_d    = mem_err_q;
        pc_enable    = 1'b1;
        if_id_enable = 1'b1;
        if_id_clr    = 1'b0;
        id_ex_clr    = 1'b0;
        redirect     = 1'b0;
        if (!reset) begin
            pc_enable = 1'b0;
            if_id_clr = 1'b1;
            id_ex_clr = 1'b1;
        end else if (mispredict_e) begin
            redirect  = 1'b1;
            if_id_clr = 1'b1;
            id_ex_clr = 1'b1;
            flush_d   = FLUSH_LOAD;
            tmo_d     = 8'd0;
            state_d   = (FLUSH_LOAD != 3'd0) ? ST_FLUSH : ST_RUN;
        end else if (halt_req) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            flush_d      = 3'd0;
            tmo_d        = 8'd0;
            state_d      = ST_HALT;
        end else begin
            case (state_q)
                ST_FLUSH: begin
                    if_id_clr = 1'b1;
                    flush_d   = (flush_q != 3'd0) ? flush_q - 3'd1 : 3'd0;
                    if (flush_q <= 3'd1) begin
                        state_d = ST_RUN;
                    end
                end
                ST_HALT: begin
                    pc_enable    = 1'b0;
                    if_id_enable = 1'b0;
                    state_d      = ST_RUN;
                end
                default: begin
                    if (load_use_d) begin
                        // Hold the wait state and its timer across a load-use stall.
                        pc_enable    = 1'b0;
                        if_id_enable = 1'b0;
                        id_ex_clr    = 1'b1;
                        state_d      = (state_q == ST_WAIT_MEM) ? ST_WAIT_MEM : ST_RUN;
                    end else if (!imem_ready) begin
                        pc_enable = 1'b0;
                        if_id_clr = 1'b1;
                        state_d   = ST_WAIT_MEM;
                        tmo_base  = (state_q == ST_WAIT_MEM) ? tmo_q : 8'd0;
                        tmo_d     = (tmo_base != 8'hFF) ? tmo_base + 8'd1 : tmo_base;
                        if (tmo_d >= TMO_LIMIT) begin
                            mem_err_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_RUN;
                        tmo_d   = 8'd0;
                    end
                end
            endcase
        end
    end

    // State, bubble counter, fetch-timeout counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            flush_q   <= 3'd0;
            tmo_q     <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flush_q   <= flush_d;
            tmo_q     <= tmo_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign state_o = state_q;
    assign mem_err = mem_err_q;

`ifdef PIPE_PERF_CNT_EN
    sat_counter #(.CNT_W(CNT_W)) u_mispredict_cnt (
        .clk   (clk),
        .clear (!reset),
        .inc   (reset && mispredict_e),
        .count (mispredict_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (!reset),
        .inc   (reset && !pc_enable),
        .count (stall_cnt)
    );
`else
    assign mispredict_cnt = '0;
    assign stall_cnt      = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (FLUSH_BUBBLES=2, MEM_TIMEOUT=15),
// plus a 2-bit-counter instance sharing the same stimulus for saturation.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        mispredict_e;
    logic        load_use_d;
    logic        imem_ready;
    logic        halt_req;
    logic        pc_enable, if_id_enable, if_id_clr, id_ex_clr, redirect, mem_err;
    logic [2:0]  state_o;
    logic [31:0] mispredict_cnt, stall_cnt;
    logic        s_pc_enable, s_if_id_enable, s_if_id_clr, s_id_ex_clr, s_redirect, s_mem_err;
    logic [2:0]  s_state_o;
    logic [1:0]  s_mispredict_cnt, s_stall_cnt;
    logic [4:0]  ctrl;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_BUBBLES(2), .MEM_TIMEOUT(15), .CNT_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .mispredict_e   (mispredict_e),
        .load_use_d     (load_use_d),
        .imem_ready     (imem_ready),
        .halt_req       (halt_req),
        .pc_enable      (pc_enable),
        .if_id_enable   (if_id_enable),
        .if_id_clr      (if_id_clr),
        .id_ex_clr      (id_ex_clr),
        .redirect       (redirect),
        .mem_err        (mem_err),
        .state_o        (state_o),
        .mispredict_cnt (mispredict_cnt),
        .stall_cnt      (stall_cnt)
    );

    pipe_hazard_ctrl #(.FLUSH_BUBBLES(2), .MEM_TIMEOUT(15), .CNT_W(2)) dut_sat (
        .clk            (clk),
        .reset          (reset),
        .mispredict_e   (mispredict_e),
        .load_use_d     (load_use_d),
        .imem_ready     (imem_ready),
        .halt_req       (halt_req),
        .pc_enable      (s_pc_enable),
        .if_id_enable   (s_if_id_enable),
        .if_id_clr      (s_if_id_clr),
        .id_ex_clr      (s_id_ex_clr),
        .redirect       (s_redirect),
        .mem_err        (s_mem_err),
        .state_o        (s_state_o),
        .mispredict_cnt (s_mispredict_cnt),
        .stall_cnt      (s_stall_cnt)
    );

    // {pc_enable, if_id_enable, if_id_clr, id_ex_clr, redirect}
    assign ctrl = {pc_enable, if_id_enable, if_id_clr, id_ex_clr, redirect};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] cnt_exp(input logic [63:0] v);
        return PERF ? v : 64'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic m, input logic h, input logic l, input logic r);
        mispredict_e = m;
        halt_req     = h;
        load_use_d   = l;
        imem_ready   = r;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b1);

        // Reset behaviour
        @(negedge clk);
        check("rst_ctrl", ctrl, 5'b01110);
        tick();
        @(negedge clk);
        check("rst_state", state_o, 3'd0);
        check("rst_mem_err", mem_err, 1'b0);
        check("rst_mcnt", mispredict_cnt, 0);
        check("rst_scnt", stall_cnt, 0);
        tick();
        reset = 1'b1;

        // Idle RUN
        @(negedge clk);
        check("run_ctrl", ctrl, 5'b11000);
        tick();

        // Mispredict pulse: redirect cycle, two bubbles, back to RUN
        set_in(1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("mp_c0_ctrl", ctrl, 5'b11111);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("mp_c1_state", state_o, 3'd1);
        check("mp_c1_ctrl", ctrl, 5'b11100);
        tick();
        @(negedge clk);
        check("mp_c2_state", state_o, 3'd1);
        check("mp_c2_ctrl", ctrl, 5'b11100);
        tick();
        @(negedge clk);
        check("mp_c3_state", state_o, 3'd0);
        check("mp_c3_ctrl", ctrl, 5'b11000);
        check("mp_mcnt", mispredict_cnt, cnt_exp(1));

        // Mispredict and load-use together: mispredict only
        tick();
        set_in(1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check("mpl_ctrl", ctrl, 5'b11111);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("mpl_state", state_o, 3'd1);
        check("mpl_scnt", stall_cnt, cnt_exp(0));
        check("mpl_mcnt", mispredict_cnt, cnt_exp(2));
        tick();
        tick();

        // Load-use for three cycles
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b0, 1'b1, 1'b1);
            @(negedge clk);
            check("lu_ctrl", ctrl, 5'b00010);
            check("lu_state", state_o, 3'd0);
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("lu_end_ctrl", ctrl, 5'b11000);
        check("lu_scnt", stall_cnt, cnt_exp(3));
        tick();

        // Halt for two cycles, then release
        set_in(1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        check("halt_c0_ctrl", ctrl, 5'b00000);
        tick();
        @(negedge clk);
        check("halt_c1_state", state_o, 3'd3);
        check("halt_c1_ctrl", ctrl, 5'b00000);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("halt_rel_state", state_o, 3'd3);
        check("halt_rel_ctrl", ctrl, 5'b00000);
        tick();
        @(negedge clk);
        check("halt_exit_state", state_o, 3'd0);
        check("halt_exit_ctrl", ctrl, 5'b11000);
        check("halt_scnt", stall_cnt, cnt_exp(6));
        tick();

        // Fetch wait for 16 cycles: flag registers at the edge closing the 15th
        for (int i = 1; i <= 16; i++) begin
            set_in(1'b0, 1'b0, 1'b0, 1'b0);
            @(negedge clk);
            check("wm_ctrl", ctrl, 5'b01100);
            check("wm_state", state_o, (i == 1) ? 3'd0 : 3'd2);
            if (i == 15) check("wm_err_c15", mem_err, 1'b0);
            if (i == 16) check("wm_err_c16", mem_err, 1'b1);
            tick();
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check("wm_rdy_state", state_o, 3'd2);
        check("wm_rdy_ctrl", ctrl, 5'b11000);
        tick();
        @(negedge clk);
        check("wm_after_state", state_o, 3'd0);
        check("wm_sticky", mem_err, 1'b1);
        check("wm_scnt", stall_cnt, cnt_exp(22));
        tick();

        // Mispredict while waiting on fetch
        set_in(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("wmmp_state", state_o, 3'd2);
        check("wmmp_ctrl", ctrl, 5'b11111);
        tick();

        // Reset asserted during first flush bubble
        set_in(1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check("frst_state_pre", state_o, 3'd1);
        check("frst_ctrl", ctrl, 5'b01110);
        check("frst_mcnt_pre", mispredict_cnt, cnt_exp(3));
        check("frst_scnt_pre", stall_cnt, cnt_exp(23));
        check("sat_scnt", s_stall_cnt, 2'(cnt_exp(3)));
        check("sat_mcnt", s_mispredict_cnt, 2'(cnt_exp(3)));
        tick();
        reset = 1'b1;
        @(negedge clk);
        check("frst_state", state_o, 3'd0);
        check("frst_mcnt", mispredict_cnt, 0);
        check("frst_scnt", stall_cnt, 0);
        check("frst_mem_err", mem_err, 1'b0);
        check("frst_ctrl_run", ctrl, 5'b11000);
        tick();
        @(negedge clk);
        check("frst_stays_run", state_o, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
